// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-operand stalls, redirect flush and data-memory freeze with timeout.
// Optional performance counters are enabled by defining HZ_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       hz_d_reg_raddr1_i,
    input  logic [4:0]       hz_d_reg_raddr2_i,
    input  logic             hz_d_rs1_used_i,
    input  logic             hz_d_rs2_used_i,
    input  logic             hz_d_is_branch_i,
    input  logic             hz_d_redirect_i,
    input  logic             hz_E_reg_wen_i,
    input  logic [4:0]       hz_E_reg_waddr_i,
    input  logic             hz_E_mem_ren_i,
    input  logic             hz_m_reg_wen_i,
    input  logic [4:0]       hz_m_reg_waddr_i,
    input  logic             hz_m_mem_ren_i,
    input  logic             hz_dmem_req_i,
    input  logic             hz_dmem_ready_i,
    output logic             hz_F_stall_o,
    output logic             hz_D_stall_o,
    output logic             hz_D_flush_o,
    output logic             hz_E_flush_o,
    output logic             hz_E_stall_o,
    output logic             hz_M_stall_o,
    output logic             hz_W_bubble_o,
    output logic             hz_mem_timeout_o
`ifdef HZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] hz_stall_cnt_o,
    output logic [CNT_W-1:0] hz_memwait_cnt_o
`endif
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_VAL = WCNT_W'(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_ONE    = WCNT_W'(1);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_e;

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;

    logic match_e1, match_e2, match_m1, match_m2;
    logic e_hit, m_hit;
    logic lu_hz, be_hz, bm_hz, dep_stall;
    logic freeze;

    function automatic logic reg_match(input logic used, input logic [4:0] a,
                                       input logic wen, input logic [4:0] waddr);
        return used && (a != 5'd0) && wen && (a == waddr);
    endfunction

    always_comb begin
        match_e1  = reg_match(hz_d_rs1_used_i, hz_d_reg_raddr1_i, hz_E_reg_wen_i, hz_E_reg_waddr_i);
        match_e2  = reg_match(hz_d_rs2_used_i, hz_d_reg_raddr2_i, hz_E_reg_wen_i, hz_E_reg_waddr_i);
        match_m1  = reg_match(hz_d_rs1_used_i, hz_d_reg_raddr1_i, hz_m_reg_wen_i, hz_m_reg_waddr_i);
        match_m2  = reg_match(hz_d_rs2_used_i, hz_d_reg_raddr2_i, hz_m_reg_wen_i, hz_m_reg_waddr_i);
        e_hit     = match_e1 || match_e2;
        m_hit     = match_m1 || match_m2;
        lu_hz     = hz_E_mem_ren_i && e_hit;
        be_hz     = hz_d_is_branch_i && !hz_E_mem_ren_i && e_hit;
        bm_hz     = hz_d_is_branch_i && hz_m_mem_ren_i && m_hit;
        dep_stall = lu_hz || be_hz || bm_hz;
    end

    // Freeze covers the request cycle itself, so the pipe never moves past an unfinished access.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        freeze     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (hz_dmem_req_i && !hz_dmem_ready_i) begin
                    state_d = MEM_WAIT;
                    freeze  = 1'b1;
                end
            end
            MEM_WAIT: begin
                wait_cnt_d = (wait_cnt_q == TIMEOUT_VAL) ? wait_cnt_q : wait_cnt_q + WCNT_ONE;
                if (hz_dmem_ready_i) begin
                    state_d = RUN;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        timeout_d = timeout_q || (wait_cnt_d == TIMEOUT_VAL);
    end

    always_comb begin
        hz_F_stall_o  = 1'b0;
        hz_D_stall_o  = 1'b0;
        hz_D_flush_o  = 1'b0;
        hz_E_flush_o  = 1'b0;
        hz_E_stall_o  = 1'b0;
        hz_M_stall_o  = 1'b0;
        hz_W_bubble_o = 1'b0;
        if (!rst_n) begin
            hz_D_flush_o = 1'b1;
            hz_E_flush_o = 1'b1;
        end else if (freeze) begin
            hz_F_stall_o  = 1'b1;
            hz_D_stall_o  = 1'b1;
            hz_E_stall_o  = 1'b1;
            hz_M_stall_o  = 1'b1;
            hz_W_bubble_o = 1'b1;
        end else if (dep_stall) begin
            hz_F_stall_o = 1'b1;
            hz_D_stall_o = 1'b1;
            hz_E_flush_o = 1'b1;
        end else if (hz_d_redirect_i) begin
            hz_D_flush_o = 1'b1;
        end
    end

    assign hz_mem_timeout_o = timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef HZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

    // Both counters wrap naturally at 2^CNT_W.
    always_comb begin
        stall_cnt_d   = stall_cnt_q + (hz_F_stall_o ? CNT_W'(1) : CNT_W'(0));
        memwait_cnt_d = memwait_cnt_q + ((state_q == MEM_WAIT) ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            memwait_cnt_q <= memwait_cnt_d;
        end
    end

    assign hz_stall_cnt_o   = stall_cnt_q;
    assign hz_memwait_cnt_o = memwait_cnt_q;
`endif

endmodule
